// File: rtl/fcfs_arbiter.sv
// First-come-first-served arbiter for seven bus requesters (index 0 = no grant).
// Requests are queued in arrival order; the head of the queue holds the grant until it releases.
module fcfs_arbiter (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [7:1] req,
    output logic [7:1] grt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [2:0] queue [7];
    logic [2:0] count;
    logic [7:1] inq;

    logic [2:0] nqueue [7];
    logic [2:0] ncount;
    logic [7:1] ninq;
    logic [7:1] ngrt;
    logic [7:1] newreq;
    logic [2:0] enqidx;
    logic [2:0] pos;
    logic       deq;

    function automatic logic [7:1] onehot(input logic [2:0] idx);
        logic [7:1] r;
        for (int k = 1; k <= 7; k++) begin
            r[k] = (idx == 3'(k));
        end
        return r;
    endfunction

    // Next queue contents: dequeue shift first, then the single enqueue lands behind it.
    always_comb begin
        nqueue = queue;
        ncount = count;
        ninq   = inq;
        enqidx = 3'd0;
        pos    = count;
        newreq = req & ~inq;
        deq    = (count != 3'd0) && ((req & onehot(queue[0])) == 7'd0);

        for (int i = 7; i >= 1; i--) begin
            if (newreq[i]) begin
                enqidx = 3'(i);
            end
        end

        if (deq) begin
            for (int i = 0; i < 6; i++) begin
                nqueue[i] = queue[i + 1];
            end
            nqueue[6] = 3'd0;
            ninq      = ninq & ~onehot(queue[0]);
            ncount    = count - 3'd1;
            pos       = count - 3'd1;
        end

        if (newreq != 7'd0) begin
            nqueue[pos] = enqidx;
            ninq        = ninq | onehot(enqidx);
            ncount      = ncount + 3'd1;
        end

        ngrt = (ncount != 3'd0) ? (onehot(nqueue[0]) & req) : 7'd0;
    end

    // Control FSM; Start re-arms from either state and empties the queue.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            count <= 3'd0;
            inq   <= 7'd0;
            grt   <= 7'd0;
            for (int i = 0; i < 7; i++) begin
                queue[i] <= 3'd0;
            end
        end else if (Start) begin
            state <= RUN;
            count <= 3'd0;
            inq   <= 7'd0;
            grt   <= 7'd0;
            for (int i = 0; i < 7; i++) begin
                queue[i] <= 3'd0;
            end
        end else if (state == RUN) begin
            count <= ncount;
            inq   <= ninq;
            grt   <= ngrt;
            for (int i = 0; i < 7; i++) begin
                queue[i] <= nqueue[i];
            end
        end else begin
            grt <= 7'd0;
        end
    end

endmodule

// File: tb/tb_fcfs_arbiter.sv
// Directed bench for fcfs_arbiter: hand-computed grant values after each edge.
module tb_fcfs_arbiter;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Start = 1'b0;
    logic [7:1] req = 7'd0;
    logic [7:1] grt;

    int checks = 0;
    int errors = 0;

    fcfs_arbiter dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .req   (req),
        .grt   (grt)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [7:1] r);
        Start = s;
        req   = r;
    endtask

    task automatic checkOutput(input string tag, input logic [7:1] exp);
        checks++;
        assert (grt === exp) else begin
            errors++;
            $error("[TB] FAIL %s: grt=%b expected %b", tag, grt, exp);
        end
    endtask

    initial begin
        // Reset and IDLE behaviour
        #1 Rst = 1'b1;
        #3;
        checkOutput("reset_async", 7'b0000000);
        tick();
        Rst = 1'b0;
        checkOutput("reset_held", 7'b0000000);
        applyStimulus(1'b0, 7'b0000010);
        repeat (3) tick();
        checkOutput("idle_ignores_req", 7'b0000000);
        applyStimulus(1'b1, 7'b0000000);
        tick();
        applyStimulus(1'b0, 7'b0000000);
        checkOutput("start_clears", 7'b0000000);
        repeat (10) tick();
        checkOutput("armed_quiet", 7'b0000000);

        // Single requester, then a second one queued behind it
        applyStimulus(1'b0, 7'b0000010);
        tick();
        checkOutput("single_grant2", 7'b0000010);
        applyStimulus(1'b0, 7'b0010010);
        tick();
        checkOutput("req5_waits", 7'b0000010);
        tick();
        checkOutput("req5_still_waits", 7'b0000010);
        applyStimulus(1'b0, 7'b0010000);
        tick();
        checkOutput("release2_to5", 7'b0010000);

        // FIFO order 5,3,6
        applyStimulus(1'b0, 7'b0010100);
        repeat (10) tick();
        applyStimulus(1'b0, 7'b0110100);
        repeat (10) tick();
        checkOutput("fifo_hold5", 7'b0010000);
        applyStimulus(1'b0, 7'b0100100);
        tick();
        checkOutput("fifo_to3", 7'b0000100);
        applyStimulus(1'b0, 7'b0100000);
        tick();
        checkOutput("fifo_to6", 7'b0100000);
        applyStimulus(1'b0, 7'b0000000);
        tick();
        checkOutput("fifo_empty", 7'b0000000);

        // Simultaneous arrival of 2,5,7
        applyStimulus(1'b0, 7'b1010010);
        tick();
        checkOutput("simul_first2", 7'b0000010);
        repeat (2) tick();
        checkOutput("simul_hold2", 7'b0000010);
        applyStimulus(1'b0, 7'b1010000);
        tick();
        checkOutput("simul_to5", 7'b0010000);
        applyStimulus(1'b0, 7'b1000000);
        tick();
        checkOutput("simul_to7", 7'b1000000);
        applyStimulus(1'b0, 7'b0000000);
        tick();
        checkOutput("simul_empty", 7'b0000000);

        // Non-head requester 4 drops out while queued behind 2
        applyStimulus(1'b0, 7'b1001010);
        repeat (3) tick();
        checkOutput("nonhead_q247", 7'b0000010);
        applyStimulus(1'b0, 7'b1000010);
        tick();
        checkOutput("nonhead_drop4", 7'b0000010);
        applyStimulus(1'b0, 7'b1000000);
        tick();
        checkOutput("nonhead_mask4", 7'b0000000);
        tick();
        checkOutput("nonhead_to7", 7'b1000000);

        // Start while running empties the queue; lines re-enter lowest first
        applyStimulus(1'b0, 7'b1000010);
        tick();
        checkOutput("run_hold7", 7'b1000000);
        applyStimulus(1'b1, 7'b1000010);
        tick();
        applyStimulus(1'b0, 7'b1000010);
        checkOutput("restart_clear", 7'b0000000);
        tick();
        checkOutput("restart_2first", 7'b0000010);
        tick();
        applyStimulus(1'b0, 7'b1000000);
        tick();
        checkOutput("restart_then7", 7'b1000000);

        // Asynchronous reset with three queued, then re-arm
        applyStimulus(1'b0, 7'b1010100);
        repeat (2) tick();
        checkOutput("pre_reset_7", 7'b1000000);
        #3 Rst = 1'b1;
        #1;
        checkOutput("mid_reset_async", 7'b0000000);
        tick();
        Rst = 1'b0;
        tick();
        checkOutput("post_reset_idle", 7'b0000000);
        applyStimulus(1'b1, 7'b1010100);
        tick();
        applyStimulus(1'b0, 7'b1010100);
        checkOutput("rearm_clear", 7'b0000000);
        tick();
        checkOutput("rearm_3first", 7'b0000100);
        repeat (2) tick();
        applyStimulus(1'b0, 7'b1010000);
        tick();
        checkOutput("rearm_to5", 7'b0010000);
        applyStimulus(1'b0, 7'b1000000);
        tick();
        checkOutput("rearm_to7", 7'b1000000);
        applyStimulus(1'b0, 7'b0000000);
        tick();
        checkOutput("rearm_empty", 7'b0000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
